// File: rtl/clk_rst_seq.sv
// clk_rst_seq: staggered per-channel reset release sequencer with per-channel clock-enable dividers
// Ports: clk, rst (async active-low), sw_rst_req (sync restart), ch_en / div_ratio (per-channel gate and ratio),
//        ch_rst_n / ch_ce (registered per-channel reset and enable pulses), seq_busy, seq_done.
module clk_rst_seq #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_rst_req,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  output logic [NUM_CH-1:0]       ch_rst_n,
  output logic [NUM_CH-1:0]       ch_ce,
  output logic                    seq_busy,
  output logic                    seq_done
);
  localparam int LAST = HOLD_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int SW = $clog2(LAST + 1);
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] sc, sc_nxt;
  logic [NUM_CH-1:0] rel_nxt;
  always_comb begin
    sc_nxt = sw_rst_req ? '0 : (sc == SW'(LAST)) ? sc : sc + SW'(1);
    state_nxt = sw_rst_req ? HOLD : (sc_nxt == SW'(LAST)) ? RUN : (sc_nxt >= SW'(HOLD_CYCLES)) ? RELEASE : HOLD;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HOLD;
      sc <= '0;
      ch_rst_n <= '0;
      seq_busy <= 1'b1;
      seq_done <= 1'b0;
    end else begin
      state <= state_nxt;
      sc <= sc_nxt;
      ch_rst_n <= rel_nxt;
      seq_busy <= state_nxt != RUN;
      seq_done <= state != RUN && state_nxt == RUN;
    end
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DIV_W-1:0] cnt, lat, r_eff;
    logic arm, act, ce;
    assign rel_nxt[k] = !sw_rst_req && (sc_nxt >= SW'(HOLD_CYCLES + k * STAGGER));
    // arm lags ch_rst_n by one edge so the divider starts the cycle after release
    assign act = ch_rst_n[k] & arm & ch_en[k] & ~sw_rst_req;
    // a fresh ratio is taken only at the start of a period
    assign r_eff = (cnt == '0) ? div_ratio[k*DIV_W +: DIV_W] : lat;
    assign ch_ce[k] = ce;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
        lat <= '0;
        arm <= 1'b0;
        ce <= 1'b0;
      end else begin
        arm <= ch_rst_n[k];
        cnt <= (act && cnt != r_eff) ? cnt + DIV_W'(1) : '0;
        lat <= r_eff;
        ce <= act && cnt == r_eff;
      end
    end
  end
endmodule
